// File: rtl/tap_scan_ctrl.sv
// Input-delay tap sweep for one serial lane: builds the per-tap pass/fail vector
// against a training word, then applies the centre tap returned by the position finder.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | present tap_out with a 1-cycle tap_ld strobe
// SETTLE | let the delay element settle, rx_word ignored
// SAMPLE | compare rx_word against PATTERN, sticky fail
// RECORD | write pass/fail bit for current tap, advance or finish
// REPORT | scan_vec complete, waiting for centre tap or restart
// APPLY  | load the clamped centre tap
// LOCKED | centre tap applied
module tap_scan_ctrl #(
    parameter int              WIDTH         = 56,
    parameter int              DW            = 8,
    parameter logic [DW-1:0]   PATTERN       = 8'hA5,
    parameter int              SETTLE_CYCLES = 16,
    parameter int              SAMPLE_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    rx_word,
    output logic [6:0]       tap_out,
    output logic             tap_ld,
    output logic [WIDTH-1:0] scan_vec,
    output logic             scan_valid,
    output logic             scan_err,
    input  logic [6:0]       center_tap,
    input  logic             center_valid,
    output logic             busy,
    output logic             locked
);

    localparam int         CMAX     = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int         CW       = $clog2(CMAX) + 1;
    localparam logic [6:0] TAP_LAST = 7'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, SETTLE, SAMPLE, RECORD, REPORT, APPLY, LOCKED
    } state_t;

    state_t         state, state_nx;
    logic [6:0]     tap;
    logic [CW-1:0]  cnt;
    logic           fail;
    logic           start_acc;
    logic [6:0]     center_clamped;

    assign center_clamped = (center_tap > TAP_LAST) ? TAP_LAST : center_tap;
    assign tap_out        = tap;
    assign scan_err       = scan_valid && (scan_vec == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        tap_ld    = 1'b0;
        busy      = 1'b0;
        locked    = 1'b0;
        start_acc = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nx  = LOAD;
                end
            end
            LOAD: begin
                tap_ld   = 1'b1;
                busy     = 1'b1;
                state_nx = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = SAMPLE;
            end
            SAMPLE: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = RECORD;
            end
            RECORD: begin
                busy     = 1'b1;
                state_nx = (tap == TAP_LAST) ? REPORT : LOAD;
            end
            REPORT: begin
                // a simultaneous restart takes priority over the centre tap
                if (start) begin
                    start_acc = 1'b1;
                    state_nx  = LOAD;
                end else if (center_valid) begin
                    state_nx = APPLY;
                end
            end
            APPLY: begin
                tap_ld   = 1'b1;
                busy     = 1'b1;
                state_nx = LOCKED;
            end
            LOCKED: begin
                locked = 1'b1;
                if (start) begin
                    start_acc = 1'b1;
                    state_nx  = LOAD;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap        <= '0;
            cnt        <= '0;
            fail       <= 1'b0;
            scan_vec   <= '0;
            scan_valid <= 1'b0;
        end else if (start_acc) begin
            tap        <= '0;
            fail       <= 1'b0;
            scan_vec   <= '0;
            scan_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: cnt <= CW'(SETTLE_CYCLES - 1);
                SETTLE: begin
                    if (cnt == '0) cnt <= CW'(SAMPLE_CYCLES - 1);
                    else           cnt <= cnt - 1'b1;
                end
                SAMPLE: begin
                    if (rx_word != PATTERN) fail <= 1'b1;
                    if (cnt != '0)          cnt  <= cnt - 1'b1;
                end
                RECORD: begin
                    for (int k = 0; k < WIDTH; k++) begin
                        if (tap == 7'(k)) scan_vec[k] <= ~fail;
                    end
                    fail <= 1'b0;
                    if (tap == TAP_LAST) scan_valid <= 1'b1;
                    else                 tap        <= tap + 7'd1;
                end
                REPORT: begin
                    if (center_valid) tap <= center_clamped;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_scan_ctrl.sv
// Self-checking bench for tap_scan_ctrl: table-driven scans with a tap_ld/result
// scoreboard, plus hand sequences for centre-tap apply, restart priority and reset abort.
module tb_tap_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rx_word = 8'hA5;
    logic [6:0] tap_out;
    logic       tap_ld;
    logic [7:0] scan_vec;
    logic       scan_valid;
    logic       scan_err;
    logic [6:0] center_tap = 7'd0;
    logic       center_valid = 1'b0;
    logic       busy;
    logic       locked;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tap_scan_ctrl #(
        .WIDTH(8), .DW(8), .PATTERN(8'hA5), .SETTLE_CYCLES(2), .SAMPLE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rx_word(rx_word),
        .tap_out(tap_out), .tap_ld(tap_ld), .scan_vec(scan_vec),
        .scan_valid(scan_valid), .scan_err(scan_err),
        .center_tap(center_tap), .center_valid(center_valid),
        .busy(busy), .locked(locked)
    );

    typedef struct {
        logic [7:0] samp;
        logic [7:0] settle;
        bit         allbad;
        int         busy_start;
        bit         with_cv;
        logic [7:0] exp_vec;
        bit         exp_err;
    } vec_t;

    typedef struct { int cyc; logic [6:0] tap; } ld_t;
    typedef struct { logic [7:0] vec; bit err; } res_t;

    vec_t vecs[5];
    ld_t  ldq[$];
    res_t resq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per tap: cycle 1+8k LOAD, +1..+2 SETTLE, +3..+6 SAMPLE, +7 RECORD
    function automatic logic [7:0] rxval(input vec_t v, input int c);
        int k, ph;
        if (v.allbad) return 8'h3C;
        if (c < 1) return 8'hA5;
        k  = (c - 1) / 8;
        ph = (c - 1) % 8;
        if (k < 8) begin
            if (v.samp[k] && ph == 4)   return 8'h00;
            if (v.settle[k] && ph == 1) return 8'h00;
        end
        return 8'hA5;
    endfunction

    task automatic run_scan(input vec_t v);
        int         c;
        bit         done;
        logic [6:0] prev_tap;
        ld_t        e;
        res_t       r;
        for (int k = 0; k < 8; k++) ldq.push_back('{1 + 8 * k, 7'(k)});
        resq.push_back('{v.exp_vec, v.exp_err});
        start        = 1'b1;
        center_valid = v.with_cv;
        center_tap   = 7'd3;
        rx_word      = rxval(v, 0);
        step();
        start        = 1'b0;
        center_valid = 1'b0;
        c            = 1;
        done         = 0;
        prev_tap     = tap_out;
        while (!done && c < 120) begin
            rx_word = rxval(v, c);
            start   = (v.busy_start != 0 && c == v.busy_start);
            if (c == 1) begin
                chk("cleared_scan_valid", scan_valid, 0);
                chk("cleared_locked", locked, 0);
            end
            if (tap_ld) begin
                if (ldq.size() == 0) chk("extra_tap_ld_cycle", c, 0);
                else begin
                    e = ldq.pop_front();
                    chk("tap_ld_cycle", c, e.cyc);
                    chk("tap_ld_value", tap_out, e.tap);
                end
            end else begin
                chk("tap_out_hold", tap_out, prev_tap);
            end
            prev_tap = tap_out;
            if (scan_valid) begin
                r = resq.pop_front();
                chk("scan_valid_cycle", c, 65);
                chk("scan_vec", scan_vec, r.vec);
                chk("scan_err", scan_err, r.err);
                chk("busy_report", busy, 0);
                done = 1;
            end else begin
                chk("busy_scan", busy, 1);
                chk("locked_scan", locked, 0);
                step();
                c++;
            end
        end
        start = 1'b0;
        if (!done) chk("scan_timeout", 0, 1);
        chk("tap_ld_missing", ldq.size(), 0);
    endtask

    task automatic apply_center(input logic [6:0] ct, input logic [6:0] exp_tap, input logic [7:0] exp_vec);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("report_no_ld", tap_ld, 0);
            chk("report_vec_stable", scan_vec, exp_vec);
            chk("report_locked", locked, 0);
        end
        center_tap   = ct;
        center_valid = 1'b1;
        step();
        center_valid = 1'b0;
        center_tap   = 7'd0;
        chk("apply_ld", tap_ld, 1);
        chk("apply_tap", tap_out, exp_tap);
        chk("apply_busy", busy, 1);
        step();
        chk("locked_no_ld", tap_ld, 0);
        chk("locked", locked, 1);
        chk("locked_tap", tap_out, exp_tap);
        chk("locked_scan_valid", scan_valid, 1);
        chk("locked_scan_vec", scan_vec, exp_vec);
        // a stray centre strobe outside REPORT must not reload
        center_tap   = 7'd1;
        center_valid = 1'b1;
        step();
        center_valid = 1'b0;
        chk("stray_cv_no_ld", tap_ld, 0);
        chk("stray_cv_tap", tap_out, exp_tap);
        step();
        chk("stray_cv_tap2", tap_out, exp_tap);
        chk("stray_cv_locked", locked, 1);
    endtask

    task automatic reset_abort();
        start   = 1'b1;
        rx_word = 8'hA5;
        step();
        start = 1'b0;
        repeat (19) step();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_tap_ld", tap_ld, 0);
        chk("rst_tap_out", tap_out, 0);
        chk("rst_scan_vec", scan_vec, 0);
        chk("rst_scan_valid", scan_valid, 0);
        chk("rst_scan_err", scan_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 2) rst = 1'b0;
            chk("post_rst_no_ld", tap_ld, 0);
            chk("post_rst_idle", busy, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b0, 0,  1'b0, 8'hFF, 1'b0};
        vecs[1] = '{8'hC3, 8'h00, 1'b0, 10, 1'b0, 8'h3C, 1'b0};
        vecs[2] = '{8'h00, 8'hFF, 1'b0, 40, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 0,  1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'h5A, 8'h81, 1'b0, 0,  1'b0, 8'hA5, 1'b0};

        step();
        step();
        chk("reset_tap_out", tap_out, 0);
        chk("reset_tap_ld", tap_ld, 0);
        chk("reset_scan_vec", scan_vec, 0);
        chk("reset_scan_valid", scan_valid, 0);
        chk("reset_scan_err", scan_err, 0);
        chk("reset_busy", busy, 0);
        chk("reset_locked", locked, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            if (i == 4) reset_abort();
            run_scan(vecs[i]);
            if (i == 0) apply_center(7'd4, 7'd4, 8'hFF);
            if (i == 1) apply_center(7'd100, 7'd7, 8'h3C);
            if (i == 3) begin
                repeat (4) step();
                chk("err_held", scan_err, 1);
                chk("err_vec_held", scan_vec, 8'h00);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
